// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions for the routed transmitter and the
//               matching receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic UART_IDLE_LEVEL      = 1'b1;
    localparam int   DEFAULT_CLKS_PER_BIT = 434;
    localparam logic SEL_XBEE             = 1'b1;
    localparam logic SEL_GPS              = 1'b0;

    // Cycles from the first start-bit cycle to the last stop-bit cycle.
    function automatic int frame_cycles(input int clks_per_bit, input int stop_bits);
        return (9 + stop_bits) * clks_per_bit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_route_tx_if.sv
// ============================================================================
// Module      : uart_route_tx_if
// Description : Byte handshake and routed serial lines of the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_route_tx_if;
    logic [7:0] TxData;
    logic       TxValid;
    logic       TxReady;
    logic       XbeeGpsSelect;
    logic       XbeeRx;
    logic       GpsRx;
    logic       Busy;

    modport master (
        output TxData,
        output TxValid,
        output XbeeGpsSelect,
        input  TxReady,
        input  XbeeRx,
        input  GpsRx,
        input  Busy
    );

    modport slave (
        input  TxData,
        input  TxValid,
        input  XbeeGpsSelect,
        output TxReady,
        output XbeeRx,
        output GpsRx,
        output Busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_baud_counter.sv
// ============================================================================
// Module      : uart_baud_counter
// Description : Bit-period counter; pulses o_tick on the last cycle of a bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_en,
    input  wire logic i_clr,
    output logic      o_tick
);

    localparam int             CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == c_LAST);
    assign o_tick = i_en & w_last & ~i_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_route_tx.sv
// ============================================================================
// Module      : uart_route_tx
// Description : 8N1 UART transmitter routing each frame to the Xbee or GPS line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_route_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  wire logic       Clk,
    input  wire logic       ResetN,
    uart_route_tx_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_START = START;
    localparam logic [1:0] S_DATA  = DATA;
    localparam logic [1:0] S_STOP  = STOP;

    localparam logic [2:0] c_LAST_DATA_BIT = 3'd7;
    localparam logic [2:0] c_LAST_STOP_BIT = 3'(STOP_BITS - 1);

    logic [1:0] r_state;
    logic [2:0] r_bit;
    logic [7:0] r_data;
    logic       r_sel;
    logic       r_xbee;
    logic       r_gps;

    logic [1:0] w_state_nxt;
    logic [2:0] w_bit_nxt;
    logic [7:0] w_data_nxt;
    logic       w_sel_nxt;
    logic       w_level_nxt;
    logic       w_accept;
    logic       w_tick;

    assign w_accept = (r_state == S_IDLE) & bus.TxValid;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (Clk),
        .rst_n  (ResetN),
        .i_en   (r_state != S_IDLE),
        .i_clr  (w_accept),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_bit_nxt   = 3'd0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit == c_LAST_DATA_BIT) begin
                        w_state_nxt = S_STOP;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // The bit counter indexes stop bits when more than one is sent.
                if (w_tick) begin
                    if (r_bit == c_LAST_STOP_BIT) begin
                        w_state_nxt = S_IDLE;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_bit_nxt   = 3'd0;
            end
        endcase
    end

    assign w_data_nxt = w_accept ? bus.TxData        : r_data;
    assign w_sel_nxt  = w_accept ? bus.XbeeGpsSelect : r_sel;

    // Line level is computed from the next state so the flopped outputs change
    // on the same edge as the state, starting the start bit right after accept.
    always_comb begin
        w_level_nxt = UART_IDLE_LEVEL;
        case (w_state_nxt)
            S_START: w_level_nxt = 1'b0;
            S_DATA:  w_level_nxt = w_data_nxt[w_bit_nxt];
            default: w_level_nxt = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= S_IDLE;
            r_bit   <= 3'd0;
            r_data  <= 8'h00;
            r_sel   <= SEL_GPS;
            r_xbee  <= UART_IDLE_LEVEL;
            r_gps   <= UART_IDLE_LEVEL;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_bit_nxt;
            r_data  <= w_data_nxt;
            r_sel   <= w_sel_nxt;
            r_xbee  <= (w_sel_nxt == SEL_XBEE) ? w_level_nxt : UART_IDLE_LEVEL;
            r_gps   <= (w_sel_nxt == SEL_GPS)  ? w_level_nxt : UART_IDLE_LEVEL;
        end
    end

    assign bus.TxReady = (r_state == S_IDLE);
    assign bus.Busy    = (r_state != S_IDLE);
    assign bus.XbeeRx  = r_xbee;
    assign bus.GpsRx   = r_gps;

endmodule

`default_nettype wire

// File: tb/tb_uart_route_tx.sv
// ============================================================================
// Module      : tb_uart_route_tx
// Description : Directed, table-driven bench for the routed UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_route_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d;
    logic       s;
    logic       v;
    int         cur;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    uart_route_tx_if if0 ();
    uart_route_tx_if if1 ();
    uart_route_tx_if if2 ();

    assign if0.TxData = d;  assign if0.XbeeGpsSelect = s;  assign if0.TxValid = v && (cur == 0);
    assign if1.TxData = d;  assign if1.XbeeGpsSelect = s;  assign if1.TxValid = v && (cur == 1);
    assign if2.TxData = d;  assign if2.XbeeGpsSelect = s;  assign if2.TxValid = v && (cur == 2);

    uart_route_tx #(.CLKS_PER_BIT(4),   .STOP_BITS(1)) dut0 (.Clk(clk), .ResetN(rst_n), .bus(if0));
    uart_route_tx #(.CLKS_PER_BIT(4),   .STOP_BITS(2)) dut1 (.Clk(clk), .ResetN(rst_n), .bus(if1));
    uart_route_tx #(.CLKS_PER_BIT(434), .STOP_BITS(1)) dut2 (.Clk(clk), .ResetN(rst_n), .bus(if2));

    localparam int CPB [3] = '{4, 4, 434};
    localparam int SB  [3] = '{1, 2, 1};

    logic m_x, m_g, m_r, m_b;
    always_comb begin
        m_x = if0.XbeeRx; m_g = if0.GpsRx; m_r = if0.TxReady; m_b = if0.Busy;
        case (cur)
            1: begin m_x = if1.XbeeRx; m_g = if1.GpsRx; m_r = if1.TxReady; m_b = if1.Busy; end
            2: begin m_x = if2.XbeeRx; m_g = if2.GpsRx; m_r = if2.TxReady; m_b = if2.Busy; end
            default: ;
        endcase
    end

    // frame: bit i is the i-th line level sent, i.e. {stop, data, start}
    typedef struct {
        int         dut;
        logic [7:0] data;
        logic       sel;
        logic       tog;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, got, want);
        end
    endtask

    task automatic start_frame(input logic [7:0] data, input logic sel, input logic hold);
        @(negedge clk);
        d = data; s = sel; v = 1'b1;
        chk("ready_before_accept", int'(m_r), 1);
        @(posedge clk);
        #1;
        if (!hold) v = 1'b0;
    endtask

    task automatic frame_body(input logic [9:0] fr, input logic sel, input int cpb,
                              input int sb, input logic tog);
        int   n;
        int   idx;
        logic e;
        n = (9 + sb) * cpb;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            idx = c / cpb;
            e   = (idx > 9) ? 1'b1 : fr[idx];
            if (sel) chk("frame_cycle_xbee", int'({m_x, m_g, m_r, m_b}), int'({e, 3'b101}));
            else     chk("frame_cycle_gps",  int'({m_g, m_x, m_r, m_b}), int'({e, 3'b101}));
            if (tog) begin
                s = ~s;
                d = d + 8'h5B;
            end
        end
    endtask

    task automatic idle_chk(input string nm);
        @(negedge clk);
        chk(nm, int'({m_x, m_g, m_r, m_b}), int'(4'b1110));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{0, 8'hA5, 1'b1, 1'b0, 10'h34A};
        vecs[1] = '{0, 8'h3C, 1'b0, 1'b1, 10'h278};
        vecs[2] = '{0, 8'h81, 1'b0, 1'b0, 10'h302};
        vecs[3] = '{1, 8'hFF, 1'b1, 1'b0, 10'h3FE};
        vecs[4] = '{2, 8'h00, 1'b1, 1'b0, 10'h200};

        rst_n = 1'b0; v = 1'b0; d = 8'h00; s = 1'b0; cur = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            cur = k;
            #0;
            chk("reset_state", int'({m_x, m_g, m_r, m_b}), int'(4'b1110));
        end
        cur = 0;
        rst_n = 1'b1;

        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            chk("idle_all", int'({if0.XbeeRx, if0.GpsRx, if0.TxReady, if0.Busy,
                                  if1.XbeeRx, if1.GpsRx, if1.TxReady, if1.Busy,
                                  if2.XbeeRx, if2.GpsRx, if2.TxReady, if2.Busy}),
                int'(12'hEEE));
        end

        for (int i = 0; i < 5; i++) begin
            cur = vecs[i].dut;
            start_frame(vecs[i].data, vecs[i].sel, 1'b0);
            frame_body(vecs[i].frame, vecs[i].sel, CPB[cur], SB[cur], vecs[i].tog);
            idle_chk("idle_after_frame");
        end

        // Back-to-back with TxValid held, two stop bits.
        cur = 1;
        start_frame(8'h55, 1'b1, 1'b1);
        d = 8'hAA;
        frame_body(10'h2AA, 1'b1, 4, 2, 1'b0);
        idle_chk("b2b_single_idle_cycle");
        @(posedge clk);
        #1;
        v = 1'b0;
        frame_body(10'h354, 1'b1, 4, 2, 1'b0);
        idle_chk("b2b_idle_after_second");

        // Asynchronous reset during data bit 3.
        cur = 0;
        start_frame(8'hA5, 1'b1, 1'b0);
        repeat (17) @(negedge clk);
        chk("line_low_in_bit3", int'(m_x), 0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_lines", int'({m_x, m_g, m_r}), int'(3'b111));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) idle_chk("post_reset_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
